mt_regfile: RTL and testbench
=============================

# mt_regfile

Parametrised multi-thread register file for the matrix core: `THREAD_CNT` threads × `REG_CNT` registers of `REG_WIDTH` bits, `WR_PORTS` write ports, `RD_PORTS` registered read ports. It sits between issue and the matrix datapath, replacing the fixed 2R/2W file. It adds the following on top of that file:
- a hardware zeroing sweep after reset;
- a per-thread clear command;
- deterministic same-address write priority;
- a collision flag;
- optional write-to-read bypass.

## Interface
- `REG_CNT`, 4, registers per thread (power of two)
- `THREAD_CNT`, 4, hardware threads (power of two)
- `REG_WIDTH`, 288, bits per register (4x4 of 18-bit)
- `RD_PORTS`, 2, read ports (1..4)
- `WR_PORTS`, 2, write ports (1..4)
- `clk`  in  1  clock, all state on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `rd_addr`  in  `RD_PORTS*ADDR_W`  per-port address {tid, reg}, port p at `[p*ADDR_W +: ADDR_W]`
- `rd_en`  in  `RD_PORTS`  per-port read request
- `rd_data`  out  `RD_PORTS*REG_WIDTH`  registered read data
- `rd_valid`  out  `RD_PORTS`  registered; high when `rd_data` slice holds a serviced read
- `wr_en`  in  `WR_PORTS`  per-port write enable
- `wr_addr`  in  `WR_PORTS*ADDR_W`  per-port write address
- `wr_data`  in  `WR_PORTS*REG_WIDTH`  per-port write data
- `clr_req`  in  1  request zeroing of one thread's registers
- `clr_tid`  in  `TID_W`  thread to clear, sampled with `clr_req`
- `ready`  out  1  high in IDLE only; accesses accepted only when high
- `wr_collision`  out  1  registered; two or more enabled write ports hit the same address last cycle

## Operation
- Address widths: `ADDR_W = $clog2(REG_CNT*THREAD_CNT)`, `TID_W = $clog2(THREAD_CNT)`. Address = `tid*REG_CNT + reg`.
- FSM states:
  - INIT: sweep all entries to zero, one per cycle, index 0 up to `REG_CNT*THREAD_CNT-1`; then go to IDLE.
  - IDLE: normal access.
  - CLEAR: zero entries `clr_tid*REG_CNT` through `+REG_CNT-1`, one per cycle; then go to IDLE.
- IDLE → CLEAR when `clr_req` is high in IDLE. The tid is latched on that edge.
- Writes and reads presented in the same cycle as an accepted `clr_req` are serviced normally. The clear then overwrites those writes.
- When `ready` is low:
  - `wr_en` and `rd_en` are ignored: no state change, and `rd_valid` is 0 on the next cycle.
  - `clr_req` is ignored (not queued).
- Write priority: when several enabled ports target one address, the highest-numbered port wins and `wr_collision` pulses for 1 cycle. Writes to different addresses all commit.
- Reads: when `rd_en[p]` is set, `rd_data[p]` and `rd_valid[p]` update on the next edge. When `rd_en[p]` is low, `rd_data[p]` holds its value and `rd_valid[p]` goes to 0.
- Reset values: `rd_data` 0, `rd_valid` 0, `ready` 0, `wr_collision` 0, FSM in INIT, sweep counter 0.
- Reset asserted in any state, including mid-CLEAR, aborts the operation. A full INIT is rerun after release.

## Timing
- Read latency: 1 cycle, address at edge N, data valid after edge N+1.
- Write commit: 1 edge. A read of the same address on the following cycle sees the new data.
- Same-cycle read/write of one address: behaviour is set by the macro (see Configuration).
- INIT duration:
  - `ready` first rises `REG_CNT*THREAD_CNT` cycles after `rst_n` deasserts (16 for defaults).
- CLEAR duration:
  - `ready` falls the edge after `clr_req` is accepted and rises again `REG_CNT` cycles later.

## Configuration
- `MT_REGFILE_BYPASS_EN` defined: the read is write-first. A same-cycle read of an address being written returns the winning write port's data (priority rule applied).
- `MT_REGFILE_BYPASS_EN` undefined: the read is read-first. A same-cycle read returns the old contents, so storage can map to block RAM.

## Structure
- `regfile_pkg` holds:
  - the FSM state enum `rf_state_e` (INIT, IDLE, CLEAR);
  - the address-width helper function;
  - the default parameter constants.
- Sub-module `regfile_sweep` holds the FSM plus the sweep counter. It outputs the sweep address, the sweep write enable and `ready`.
- The top level holds storage, port arbitration, bypass muxing and the output registers.

## Test plan
- Reset release → `ready` 0 for 16 cycles then 1; reading every address returns 0.
- Write addr 5 = `'h1234` on port 0; read port 1, addr 5, next cycle → `rd_data[1]` = `'h1234` and `rd_valid[1]` = 1 one cycle later.
- Ports 0 and 1 both write addr 3 (`'hA`, `'hB`) → addr 3 reads `'hB`; `wr_collision` = 1 for exactly one cycle.
- Write addr 7 = `'h55`, then in one cycle read addr 7 and write `'h66` to it:
  - with `MT_REGFILE_BYPASS_EN`, the read returns `'h66`;
  - without it, the read returns `'h55`.
- Fill all registers with nonzero data, then `clr_req` with `clr_tid` = 2:
  - `ready` is low for 4 cycles;
  - addrs 8–11 read 0;
  - all other addrs are unchanged;
  - a write during the low-`ready` window is dropped.
- Assert `rst_n` low on the second cycle of CLEAR → after release, INIT reruns and all 16 entries read 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and constants for the multi-thread register file.
package regfile_pkg;

    typedef enum logic [1:0] {
        RF_INIT,
        RF_IDLE,
        RF_CLEAR
    } rf_state_e;

    localparam int DEF_REG_CNT    = 4;
    localparam int DEF_THREAD_CNT = 4;
    localparam int DEF_REG_WIDTH  = 288;
    localparam int DEF_RD_PORTS   = 2;
    localparam int DEF_WR_PORTS   = 2;

    // Flat address width: {tid, reg}
    function automatic int addr_w(input int reg_cnt, input int thread_cnt);
        return $clog2(reg_cnt * thread_cnt);
    endfunction

endpackage

// File: rtl/regfile_sweep.sv
// Zeroing sequencer: full sweep after reset (INIT) and per-thread sweep
// on request (CLEAR). Storage is only open to the ports while ready is high.
module regfile_sweep
    import regfile_pkg::*;
#(
    parameter int REG_CNT    = DEF_REG_CNT,
    parameter int THREAD_CNT = DEF_THREAD_CNT,
    localparam int ADDR_W    = addr_w(REG_CNT, THREAD_CNT),
    localparam int TID_W     = (THREAD_CNT > 1) ? $clog2(THREAD_CNT) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_req,
    input  logic [TID_W-1:0]  clr_tid,
    output logic [ADDR_W-1:0] sweep_addr,
    output logic              sweep_we,
    output logic              ready
);

    localparam int DEPTH  = REG_CNT * THREAD_CNT;
    localparam int REG_SH = $clog2(REG_CNT);

    rf_state_e         state;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] base;

    // Sequencer FSM; ready is registered and high only in IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RF_INIT;
            cnt   <= '0;
            base  <= '0;
            ready <= 1'b0;
        end else begin
            case (state)
                RF_INIT: begin
                    if (cnt == ADDR_W'(DEPTH - 1)) begin
                        state <= RF_IDLE;
                        cnt   <= '0;
                        ready <= 1'b1;
                    end else begin
                        cnt <= cnt + ADDR_W'(1);
                    end
                end
                RF_IDLE: begin
                    if (clr_req) begin
                        state <= RF_CLEAR;
                        cnt   <= '0;
                        base  <= ADDR_W'(clr_tid) << REG_SH;
                        ready <= 1'b0;
                    end
                end
                RF_CLEAR: begin
                    if (cnt == ADDR_W'(REG_CNT - 1)) begin
                        state <= RF_IDLE;
                        cnt   <= '0;
                        ready <= 1'b1;
                    end else begin
                        cnt <= cnt + ADDR_W'(1);
                    end
                end
                default: begin
                    state <= RF_INIT;
                    cnt   <= '0;
                    ready <= 1'b0;
                end
            endcase
        end
    end

    assign sweep_we   = (state != RF_IDLE);
    assign sweep_addr = (state == RF_CLEAR) ? (base + cnt) : cnt;

endmodule

// File: rtl/mt_regfile.sv
// Multi-thread register file: THREAD_CNT x REG_CNT entries, WR_PORTS write
// ports (highest port wins on same address), RD_PORTS registered read ports.
// Optional macro MT_REGFILE_BYPASS_EN makes same-cycle reads write-first;
// without it reads are read-first so storage can map to block RAM.
module mt_regfile
    import regfile_pkg::*;
#(
    parameter int REG_CNT    = DEF_REG_CNT,
    parameter int THREAD_CNT = DEF_THREAD_CNT,
    parameter int REG_WIDTH  = DEF_REG_WIDTH,
    parameter int RD_PORTS   = DEF_RD_PORTS,
    parameter int WR_PORTS   = DEF_WR_PORTS,
    localparam int ADDR_W    = addr_w(REG_CNT, THREAD_CNT),
    localparam int TID_W     = (THREAD_CNT > 1) ? $clog2(THREAD_CNT) : 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [RD_PORTS*ADDR_W-1:0]    rd_addr,
    input  logic [RD_PORTS-1:0]           rd_en,
    output logic [RD_PORTS*REG_WIDTH-1:0] rd_data,
    output logic [RD_PORTS-1:0]           rd_valid,
    input  logic [WR_PORTS-1:0]           wr_en,
    input  logic [WR_PORTS*ADDR_W-1:0]    wr_addr,
    input  logic [WR_PORTS*REG_WIDTH-1:0] wr_data,
    input  logic                          clr_req,
    input  logic [TID_W-1:0]              clr_tid,
    output logic                          ready,
    output logic                          wr_collision
);

    localparam int DEPTH = REG_CNT * THREAD_CNT;

    logic [REG_WIDTH-1:0]                mem [DEPTH];
    logic [ADDR_W-1:0]                   sweep_addr;
    logic                                sweep_we;
    logic                                coll_next;
    logic [RD_PORTS-1:0][REG_WIDTH-1:0]  rd_val;

    regfile_sweep #(
        .REG_CNT    (REG_CNT),
        .THREAD_CNT (THREAD_CNT)
    ) u_sweep (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_req    (clr_req),
        .clr_tid    (clr_tid),
        .sweep_addr (sweep_addr),
        .sweep_we   (sweep_we),
        .ready      (ready)
    );

    // Storage: sweep zeroing when busy, else port writes in ascending order
    // so the highest-numbered port lands last on a shared address
    always_ff @(posedge clk) begin
        if (sweep_we) begin
            mem[sweep_addr] <= '0;
        end else if (ready) begin
            for (int q = 0; q < WR_PORTS; q++) begin
                if (wr_en[q])
                    mem[wr_addr[q*ADDR_W +: ADDR_W]] <= wr_data[q*REG_WIDTH +: REG_WIDTH];
            end
        end
    end

    // Detect two or more enabled write ports on one address
    always_comb begin
        coll_next = 1'b0;
        for (int i = 0; i < WR_PORTS; i++) begin
            for (int j = i + 1; j < WR_PORTS; j++) begin
                if (wr_en[i] && wr_en[j] &&
                    wr_addr[i*ADDR_W +: ADDR_W] == wr_addr[j*ADDR_W +: ADDR_W])
                    coll_next = 1'b1;
            end
        end
    end

    // Read value per port, optionally forwarding the winning write
    always_comb begin
        rd_val = '0;
        for (int p = 0; p < RD_PORTS; p++) begin
            rd_val[p] = mem[rd_addr[p*ADDR_W +: ADDR_W]];
`ifdef MT_REGFILE_BYPASS_EN
            for (int q = 0; q < WR_PORTS; q++) begin
                if (wr_en[q] && wr_addr[q*ADDR_W +: ADDR_W] == rd_addr[p*ADDR_W +: ADDR_W])
                    rd_val[p] = wr_data[q*REG_WIDTH +: REG_WIDTH];
            end
`endif
        end
    end

    // Output registers: read data holds when not serviced, valid/collision pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data      <= '0;
            rd_valid     <= '0;
            wr_collision <= 1'b0;
        end else begin
            wr_collision <= ready & coll_next;
            for (int p = 0; p < RD_PORTS; p++) begin
                rd_valid[p] <= ready & rd_en[p];
                if (ready && rd_en[p])
                    rd_data[p*REG_WIDTH +: REG_WIDTH] <= rd_val[p];
            end
        end
    end

endmodule

// File: tb/tb_mt_regfile.sv
// Scoreboard bench for mt_regfile: the driver pushes per-cycle expectations
// from an array-based reference model; a negedge monitor pops and compares.
module tb_mt_regfile;

    localparam int RC    = 4;
    localparam int TC    = 4;
    localparam int W     = 288;
    localparam int RD    = 2;
    localparam int WR    = 2;
    localparam int AW    = 4;
    localparam int TW    = 2;
    localparam int DEPTH = RC * TC;
    localparam int RAW   = RD * AW;
    localparam int WAW   = WR * AW;
    localparam int DW    = RD * W;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [RAW-1:0]  rd_addr;
    logic [RD-1:0]   rd_en;
    logic [DW-1:0]   rd_data;
    logic [RD-1:0]   rd_valid;
    logic [WR-1:0]   wr_en;
    logic [WAW-1:0]  wr_addr;
    logic [WR*W-1:0] wr_data;
    logic            clr_req;
    logic [TW-1:0]   clr_tid;
    logic            ready;
    logic            wr_collision;

    mt_regfile #(
        .REG_CNT(RC), .THREAD_CNT(TC), .REG_WIDTH(W), .RD_PORTS(RD), .WR_PORTS(WR)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .clr_req(clr_req), .clr_tid(clr_tid),
        .ready(ready), .wr_collision(wr_collision)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            due;
        logic [RD-1:0] vld;
        logic [DW-1:0] data;
        logic          rdy;
        logic          coll;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    // reference model state
    logic [W-1:0]  m_mem [DEPTH];
    int            m_busy;
    logic [DW-1:0] m_rd;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    // monitor: compare every expectation due this cycle
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            mon_e = sb.pop_front();
            chk("rd_valid", DW'(rd_valid), DW'(mon_e.vld));
            chk("rd_data", rd_data, mon_e.data);
            chk("ready", DW'(ready), DW'(mon_e.rdy));
            chk("wr_collision", DW'(wr_collision), DW'(mon_e.coll));
        end
    end

    function automatic logic [W-1:0] rnd_word();
        logic [W-1:0] r;
        for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        m_busy = DEPTH;
        m_rd   = '0;
    endtask

    task automatic idle_inputs();
        rd_en   = '0;
        wr_en   = '0;
        clr_req = 1'b0;
        rd_addr = RAW'($urandom);
        wr_addr = WAW'($urandom);
        for (int k = 0; k < WR; k++) wr_data[k*W +: W] = rnd_word();
        clr_tid = TW'($urandom);
    endtask

    task automatic set_rd(input int p, input int a);
        rd_en[p] = 1'b1;
        rd_addr[p*AW +: AW] = AW'(a);
    endtask

    task automatic set_wr(input int p, input int a, input logic [W-1:0] d);
        wr_en[p] = 1'b1;
        wr_addr[p*AW +: AW] = AW'(a);
        wr_data[p*W +: W] = d;
    endtask

    // apply current inputs for one cycle; model predicts the post-edge outputs
    task automatic step();
        exp_t e;
        e.due  = cyc + 1;
        e.vld  = '0;
        e.coll = 1'b0;
        if (m_busy == 0) begin
            for (int p = 0; p < RD; p++) begin
                if (rd_en[p]) begin
                    int a;
                    logic [W-1:0] d;
                    a = int'(rd_addr[p*AW +: AW]);
                    d = m_mem[a];
`ifdef MT_REGFILE_BYPASS_EN
                    for (int k = 0; k < WR; k++)
                        if (wr_en[k] && int'(wr_addr[k*AW +: AW]) == a) d = wr_data[k*W +: W];
`endif
                    m_rd[p*W +: W] = d;
                    e.vld[p] = 1'b1;
                end
            end
            for (int i = 0; i < WR; i++)
                for (int j = i + 1; j < WR; j++)
                    if (wr_en[i] && wr_en[j] && wr_addr[i*AW +: AW] == wr_addr[j*AW +: AW])
                        e.coll = 1'b1;
            for (int k = 0; k < WR; k++)
                if (wr_en[k]) m_mem[int'(wr_addr[k*AW +: AW])] = wr_data[k*W +: W];
            if (clr_req) begin
                for (int r = 0; r < RC; r++) m_mem[int'(clr_tid) * RC + r] = '0;
                m_busy = RC;
            end
        end else begin
            m_busy--;
        end
        e.data = m_rd;
        e.rdy  = (m_busy == 0);
        sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) begin
            idle_inputs();
            step();
        end
    endtask

    task automatic read_all();
        for (int a = 0; a < DEPTH; a += 2) begin
            idle_inputs();
            set_rd(0, a);
            set_rd(1, a + 1);
            step();
        end
        idle_steps(1);
    endtask

    task automatic fill_all();
        for (int a = 0; a < DEPTH; a += 2) begin
            idle_inputs();
            set_wr(0, a, rnd_word() | W'(1));
            set_wr(1, a + 1, rnd_word() | W'(1));
            step();
        end
    endtask

    task automatic chk_reset_outputs();
        chk("rst rd_data", rd_data, '0);
        chk("rst rd_valid", DW'(rd_valid), '0);
        chk("rst ready", DW'(ready), '0);
        chk("rst wr_collision", DW'(wr_collision), '0);
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset_outputs();
        model_reset();
        rst_n = 1'b1;

        // INIT sweep then every entry reads zero
        idle_steps(DEPTH);
        read_all();

        // write then read on the other port
        idle_inputs(); set_wr(0, 5, W'(32'h1234)); step();
        idle_inputs(); set_rd(1, 5); step();
        idle_steps(1);

        // same-address collision, port 1 wins
        idle_inputs(); set_wr(0, 3, W'(32'hA)); set_wr(1, 3, W'(32'hB)); step();
        idle_inputs(); set_rd(0, 3); step();
        idle_steps(1);

        // same-cycle read/write of one address
        idle_inputs(); set_wr(0, 7, W'(32'h55)); step();
        idle_inputs(); set_rd(0, 7); set_wr(1, 7, W'(32'h66)); step();
        idle_inputs(); set_rd(1, 7); step();
        idle_steps(1);

        // thread clear with same-cycle access, then accesses while busy
        fill_all();
        idle_inputs(); clr_req = 1'b1; clr_tid = 2'd2; set_wr(0, 9, rnd_word()); set_rd(1, 9); step();
        idle_steps(1);
        idle_inputs(); set_wr(0, 0, rnd_word()); set_rd(1, 1); clr_req = 1'b1; clr_tid = 2'd0; step();
        idle_steps(2);
        read_all();

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            idle_inputs();
            for (int p = 0; p < RD; p++) if ($urandom_range(0, 1) == 1) set_rd(p, $urandom_range(0, DEPTH - 1));
            for (int p = 0; p < WR; p++) if ($urandom_range(0, 1) == 1) set_wr(p, $urandom_range(0, DEPTH - 1), rnd_word());
            clr_req = ($urandom_range(0, 19) == 0);
            step();
        end
        idle_steps(RC);
        read_all();

        // reset during the second cycle of CLEAR
        fill_all();
        idle_inputs(); clr_req = 1'b1; clr_tid = 2'd2; step();
        idle_steps(1);
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk_reset_outputs();
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;
        idle_steps(DEPTH);
        read_all();
        idle_steps(2);

        for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
